// File: rtl/frame_read_sched_pkg.sv
// Shared constants, FSM encoding and burst command payload for the frame
// read/write schedulers.
package frame_read_sched_pkg;

  localparam int unsigned ADDR_W          = 22;
  localparam int unsigned LEN_W           = 9;
  localparam int unsigned REMAIN_W        = 19;
  localparam int unsigned USEDW_W         = 11;
  localparam int unsigned CMP_W           = 12;
  localparam int unsigned CNT_W           = 8;

  localparam int unsigned DEF_FRAME_WORDS = 307200;
  localparam int unsigned BURST_LEN       = 256;
  localparam int unsigned FIFO_DEPTH      = 1024;
  localparam int unsigned BANK0_BASE      = 0;
  localparam int unsigned BANK1_BASE      = 524288;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CHECK,
    ST_REQ,
    ST_BURST,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } rd_cmd_t;

  // Word address of the selected ping-pong bank.
  function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
    return bank ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
  endfunction

endpackage

// File: rtl/frame_read_sched_if.sv
// Burst read request channel between the frame read scheduler (master) and
// the SDRAM controller (slave).
//   rd_req/rd_addr/rd_len : request, held stable until rd_ack
//   rd_ack                : controller accepted the request
//   rd_done               : 1-cycle pulse after the last burst word lands in the FIFO
interface frame_read_sched_if;
  import frame_read_sched_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_done;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);

endinterface

// File: rtl/frame_read_sched_sat_cnt8.sv
// 8-bit saturating event counter, cleared only by reset.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this cycle
//   cnt        : registered count, sticks at 255
module sat_cnt8
  import frame_read_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_read_sched.sv
// Schedules SDRAM read bursts that refill the display line FIFO. Reads the
// ping-pong bank the camera is not writing and restarts on every frame_start.
//   clk, rst_n      : clock, async active-low reset
//   frame_start     : 1-cycle pulse at start of vertical blanking
//   wr_bank         : bank currently written by the camera path
//   fifo_usedw      : display FIFO fill level (write side)
//   fifo_empty      : display FIFO empty (read side)
//   vga_display_en  : VGA driver in active area
//   rd              : burst request channel (master)
//   fifo_clr        : 1-cycle clear to the display FIFO
//   frame_done      : 1-cycle pulse after the last burst of a frame
//   underrun_cnt    : saturating count of display-while-empty cycles
module frame_read_sched
  import frame_read_sched_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 wr_bank,
  input  logic [USEDW_W-1:0]   fifo_usedw,
  input  logic                 fifo_empty,
  input  logic                 vga_display_en,
  frame_read_sched_if.master   rd,
  output logic                 fifo_clr,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     underrun_cnt
);

  state_t               state_q, state_n;
  logic [ADDR_W-1:0]    addr_q, addr_n;      // word offset within the read bank
  logic [REMAIN_W-1:0]  remain_q, remain_n;
  logic                 pend_q, pend_n;
  logic                 bank_q, bank_n;
  rd_cmd_t              cmd_q, cmd_n;
  logic                 req_q, req_n;
  logic                 clr_q, clr_n;
  logic                 done_q, done_n;

  logic [LEN_W-1:0]     burst_len;
  logic                 fits;

  // Next burst length and FIFO room check; widened so usedw+len cannot wrap.
  assign burst_len = (remain_q >= REMAIN_W'(BURST_LEN)) ? LEN_W'(BURST_LEN)
                                                        : LEN_W'(remain_q);
  assign fits = (CMP_W'(fifo_usedw) + CMP_W'(burst_len)) <= CMP_W'(FIFO_DEPTH);

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    remain_n = remain_q;
    pend_n   = pend_q;
    bank_n   = bank_q;
    cmd_n    = cmd_q;
    req_n    = req_q;
    clr_n    = 1'b0;
    done_n   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (frame_start) begin
          state_n = ST_FLUSH;
          clr_n   = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        bank_n   = ~wr_bank;
        addr_n   = '0;
        remain_n = REMAIN_W'(FRAME_WORDS);
        pend_n   = 1'b0;
        if (frame_start) begin
          state_n = ST_FLUSH;
          clr_n   = 1'b1;
        end else begin
          state_n = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (frame_start) begin
          state_n = ST_FLUSH;
          clr_n   = 1'b1;
        end else if (remain_q == '0) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else if (fits) begin
          state_n    = ST_REQ;
          req_n      = 1'b1;
          cmd_n.addr = bank_base(bank_q) + addr_q;
          cmd_n.len  = burst_len;
        end
      end

      // Request is never withdrawn before acceptance; a new frame is deferred.
      ST_REQ: begin
        if (frame_start) pend_n = 1'b1;
        if (rd.rd_ack) begin
          state_n = ST_BURST;
          req_n   = 1'b0;
        end
      end

      ST_BURST: begin
        if (frame_start) pend_n = 1'b1;
        if (rd.rd_done) begin
          addr_n   = addr_q + ADDR_W'(cmd_q.len);
          remain_n = remain_q - REMAIN_W'(cmd_q.len);
          if (pend_q || frame_start) begin
            state_n = ST_FLUSH;
            clr_n   = 1'b1;
          end else begin
            state_n = ST_CHECK;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pend_q   <= 1'b0;
      bank_q   <= 1'b0;
      cmd_q    <= '0;
      req_q    <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      remain_q <= remain_n;
      pend_q   <= pend_n;
      bank_q   <= bank_n;
      cmd_q    <= cmd_n;
      req_q    <= req_n;
      clr_q    <= clr_n;
      done_q   <= done_n;
    end
  end

  assign rd.rd_req   = req_q;
  assign rd.rd_addr  = cmd_q.addr;
  assign rd.rd_len   = cmd_q.len;
  assign fifo_clr    = clr_q;
  assign frame_done  = done_q;

  sat_cnt8 u_underrun (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (vga_display_en & fifo_empty),
    .cnt   (underrun_cnt)
  );

endmodule

// File: tb/tb_frame_read_sched.sv
module tb_frame_read_sched;
  import frame_read_sched_pkg::*;

  localparam int unsigned SHORT_WORDS = 600;

  typedef enum int {EV_CLR, EV_BURST, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } ev_t;

  logic clk;
  logic rst_n;

  logic               fs0, wr_bank0, fifo_empty0, vga_en0;
  logic [USEDW_W-1:0] usedw0;
  logic               clr0, fdone0;
  logic [CNT_W-1:0]   urun0;
  logic               ack_en0, auto0, ad0, md0;
  int                 cnt0;

  logic               fs1, wr_bank1, fifo_empty1, vga_en1;
  logic [USEDW_W-1:0] usedw1;
  logic               clr1, fdone1;
  logic [CNT_W-1:0]   urun1;
  logic               ad1;
  int                 cnt1;

  ev_t q0[$];
  ev_t q1[$];
  int  n_checks;
  int  n_errors;

  frame_read_sched_if bus0 ();
  frame_read_sched_if bus1 ();

  assign bus0.rd_ack  = bus0.rd_req & ack_en0;
  assign bus0.rd_done = ad0 | md0;
  assign bus1.rd_ack  = bus1.rd_req;
  assign bus1.rd_done = ad1;

  frame_read_sched dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (fs0),
    .wr_bank        (wr_bank0),
    .fifo_usedw     (usedw0),
    .fifo_empty     (fifo_empty0),
    .vga_display_en (vga_en0),
    .rd             (bus0),
    .fifo_clr       (clr0),
    .frame_done     (fdone0),
    .underrun_cnt   (urun0)
  );

  frame_read_sched #(.FRAME_WORDS(SHORT_WORDS)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (fs1),
    .wr_bank        (wr_bank1),
    .fifo_usedw     (usedw1),
    .fifo_empty     (fifo_empty1),
    .vga_display_en (vga_en1),
    .rd             (bus1),
    .fifo_clr       (clr1),
    .frame_done     (fdone1),
    .underrun_cnt   (urun1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int which, input ev_kind_t k, input int unsigned a, input int unsigned l);
    ev_t e;
    e.kind = k;
    e.addr = ADDR_W'(a);
    e.len  = LEN_W'(l);
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  task automatic observe(input int which, input ev_kind_t k,
                         input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    ev_t e;
    int  sz;
    n_checks++;
    sz = (which == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_errors++;
      $display("FAIL dut%0d unexpected event: kind %0d addr %0d len %0d", which, k, a, l);
      return;
    end
    if (which == 0) e = q0.pop_front();
    else            e = q1.pop_front();
    if ((e.kind != k) || ((k == EV_BURST) && ((e.addr !== a) || (e.len !== l)))) begin
      n_errors++;
      $display("FAIL dut%0d event: got kind %0d addr %0d len %0d, expected kind %0d addr %0d len %0d",
               which, k, a, l, e.kind, e.addr, e.len);
    end
  endtask

  // Scoreboard monitor: every accepted request, FIFO clear and frame_done pops one entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus0.rd_req && bus0.rd_ack) observe(0, EV_BURST, bus0.rd_addr, bus0.rd_len);
        if (clr0)                       observe(0, EV_CLR, '0, '0);
        if (fdone0)                     observe(0, EV_DONE, '0, '0);
        if (bus1.rd_req && bus1.rd_ack) observe(1, EV_BURST, bus1.rd_addr, bus1.rd_len);
        if (clr1)                       observe(1, EV_CLR, '0, '0);
        if (fdone1)                     observe(1, EV_DONE, '0, '0);
      end
    end
  end

  // SDRAM responders: rd_done a few cycles after acceptance.
  initial begin
    ad0 = 1'b0; cnt0 = 0;
    ad1 = 1'b0; cnt1 = 0;
    forever begin
      @(negedge clk);
      ad0 = 1'b0;
      ad1 = 1'b0;
      if (cnt0 > 0) begin cnt0--; if (cnt0 == 0) ad0 = 1'b1; end
      if (cnt1 > 0) begin cnt1--; if (cnt1 == 0) ad1 = 1'b1; end
      if (auto0 && bus0.rd_req && bus0.rd_ack) cnt0 = 3;
      if (bus1.rd_req && bus1.rd_ack)          cnt1 = 2;
    end
  end

  task automatic wait_drain(input int which, input int budget, input string nm);
    int n;
    int sz;
    n  = 0;
    sz = (which == 0) ? q0.size() : q1.size();
    while ((sz != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
      sz = (which == 0) ? q0.size() : q1.size();
    end
    check(nm, 32'(sz), 0);
  endtask

  task automatic wait_req0(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus0.rd_req && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bus0.rd_req), 1);
  endtask

  task automatic pulse_fs0();
    @(posedge clk); #1 fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;
  endtask

  task automatic pulse_md0();
    @(posedge clk); #1 md0 = 1'b1;
    @(posedge clk); #1 md0 = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " rd_req"},   32'(bus0.rd_req), 0);
    check({nm, " rd_addr"},  32'(bus0.rd_addr), 0);
    check({nm, " rd_len"},   32'(bus0.rd_len), 0);
    check({nm, " fifo_clr"}, 32'(clr0), 0);
    check({nm, " frame_done"}, 32'(fdone0), 0);
    check({nm, " underrun"}, 32'(urun0), 0);
  endtask

  initial begin
    bit seen;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b1;
    fs0 = 1'b0; wr_bank0 = 1'b1; usedw0 = '0; fifo_empty0 = 1'b0; vga_en0 = 1'b0;
    ack_en0 = 1'b1; auto0 = 1'b1; md0 = 1'b0;
    fs1 = 1'b0; wr_bank1 = 1'b1; usedw1 = '0; fifo_empty1 = 1'b0; vga_en1 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset dut1 rd_req", 32'(bus1.rd_req), 0);
    check("reset dut1 underrun", 32'(urun1), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full frame from bank 0 (camera on bank 1), FIFO empty, immediate ack.
    push(0, EV_CLR, 0, 0);
    for (int i = 0; i < 1200; i++) push(0, EV_BURST, i * 256, 256);
    push(0, EV_DONE, 0, 0);
    pulse_fs0();
    @(negedge clk); check("latency fifo_clr", 32'(clr0), 1);
    @(negedge clk); check("latency rd_req early", 32'(bus0.rd_req), 0);
    @(negedge clk); check("latency rd_req", 32'(bus0.rd_req), 1);
    wait_drain(0, 20000, "full frame drain");

    // Short frame: 256, 256, 88 then frame_done.
    push(1, EV_CLR, 0, 0);
    push(1, EV_BURST, 0, 256);
    push(1, EV_BURST, 256, 256);
    push(1, EV_BURST, 512, 88);
    push(1, EV_DONE, 0, 0);
    @(posedge clk); #1 fs1 = 1'b1;
    @(posedge clk); #1 fs1 = 1'b0;
    wait_drain(1, 200, "short frame drain");

    // Underrun counter counts and saturates.
    @(posedge clk); #1 vga_en0 = 1'b1; fifo_empty0 = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); check("underrun 10", 32'(urun0), 10);
    repeat (290) @(posedge clk);
    @(negedge clk); check("underrun sat", 32'(urun0), 255);
    @(posedge clk); #1 vga_en0 = 1'b0; fifo_empty0 = 1'b0;

    // Camera on bank 0 -> read bank 1; ack withheld 10 cycles.
    wr_bank0 = 1'b0; ack_en0 = 1'b0; auto0 = 1'b0;
    push(0, EV_CLR, 0, 0);
    push(0, EV_BURST, BANK1_BASE, 256);
    pulse_fs0();
    wait_req0("stall req seen");
    for (int k = 0; k < 10; k++) begin
      check("stall rd_req", 32'(bus0.rd_req), 1);
      check("stall rd_addr", 32'(bus0.rd_addr), BANK1_BASE);
      check("stall rd_len", 32'(bus0.rd_len), 256);
      @(negedge clk);
    end
    @(posedge clk); #1 ack_en0 = 1'b1;
    @(posedge clk); #1 wr_bank0 = 1'b1; fs0 = 1'b1;
    @(posedge clk); #1 fs0 = 1'b0;

    // frame_start during BURST: no clear until rd_done, then restart at bank 0.
    repeat (5) begin
      @(negedge clk); check("no clr during burst", 32'(clr0), 0);
    end
    push(0, EV_CLR, 0, 0);
    push(0, EV_BURST, 0, 256);
    pulse_md0();
    wait_drain(0, 20, "restart drain");

    // FIFO too full: no request until room for a whole burst.
    @(posedge clk); #1 usedw0 = 11'd800; md0 = 1'b1;
    @(posedge clk); #1 md0 = 1'b0;
    repeat (10) begin
      @(negedge clk); check("no req at usedw 800", 32'(bus0.rd_req), 0);
    end
    push(0, EV_BURST, 256, 256);
    @(posedge clk); #1 usedw0 = 11'd768;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus0.rd_req) seen = 1'b1;
    end
    check("req within 2 at usedw 768", 32'(seen), 1);
    wait_drain(0, 10, "room drain");

    // Reset while a request is pending.
    @(posedge clk); #1 ack_en0 = 1'b0; md0 = 1'b1;
    @(posedge clk); #1 md0 = 1'b0; usedw0 = '0;
    wait_req0("pre-reset req seen");
    check("pre-reset rd_addr", 32'(bus0.rd_addr), 512);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-req reset");
    @(posedge clk); #1 rst_n = 1'b1; ack_en0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle after reset rd_req", 32'(bus0.rd_req), 0);
      check("idle after reset fifo_clr", 32'(clr0), 0);
    end

    check("dut0 queue empty", 32'(q0.size()), 0);
    check("dut1 queue empty", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
